if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues fetches to the instruction memory over a
//  req/ack handshake, and presents {pc_out, instruction} to the IF/ID pipeline register.

---
 rtl/if_fetch_stage.sv | 111 +++++++++++
 tb/tb_if_fetch_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches over a req/ack handshake and feeds the IF/ID register,
// with a one-entry skid buffer for responses that land while the pipeline is stalled.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        freeze,
  input  logic        sram_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d, target_q, target_d;
  logic        valid_q, valid_d;
  logic        stall, slot_free;
  logic [31:0] pc_inc;
  assign stall     = freeze | ~sram_ready;
  assign slot_free = ~valid_q | ~stall;
  assign pc_inc    = pc_q + 32'(PC_STEP);
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q & stall;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    target_d     = target_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack && branch_taken) begin
          pc_d = branch_addr;
        end else if (imem_ack && slot_free) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_inc;
          valid_d  = 1'b1;
          pc_d     = pc_inc;
        end else if (imem_ack) begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc_inc;
          pc_d         = pc_inc;
          state_d      = SKID;
        end else if (branch_taken) begin
          target_d = branch_addr;
          state_d  = DRAIN;
        end
      end
      SKID: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          state_d = FETCH;
        end else if (slot_free) begin
          instr_d  = skid_instr_q;
          pc_out_d = skid_pc_q;
          valid_d  = 1'b1;
          state_d  = FETCH;
        end
      end
      default: begin
        // the old request must complete before the redirect target can be issued
        target_d = branch_taken ? branch_addr : target_q;
        if (imem_ack) begin
          pc_d    = branch_taken ? branch_addr : target_q;
          state_d = FETCH;
        end
      end
    endcase
    if (branch_taken) valid_d = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      target_q     <= target_d;
    end
  end
  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: per-cycle directed vectors for the fetch stage plus an async-reset sequence.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n, freeze, sram_ready, branch_taken, imem_ack;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, instruction, pc_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        frz, srdy, bt;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins, pco;
  } vec_t;
  vec_t tv[29];
  always #5 clk = ~clk;
  if_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .sram_ready(sram_ready),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .instruction(instruction), .pc_out(pc_out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  initial begin
    //         frz  srdy bt   baddr         ack  rdata         req  addr          vld  ins           pco
    tv[0]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
    tv[1]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0000,1'b1,32'h0,        1'b1,32'hE000_0000,32'h4};
    tv[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0004,1'b1,32'h4,        1'b1,32'hE000_0004,32'h8};
    tv[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0008,1'b1,32'h8,        1'b1,32'hE000_0008,32'hC};
    tv[4]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_000C,1'b1,32'hC,        1'b1,32'hE000_000C,32'h10};
    tv[5]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h10,       1'b0,32'hE000_000C,32'h10};
    tv[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h10,       1'b0,32'hE000_000C,32'h10};
    tv[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h10,       1'b0,32'hE000_000C,32'h10};
    tv[8]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0010,1'b1,32'h10,       1'b1,32'hE000_0010,32'h14};
    tv[9]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,32'hE000_0014,1'b1,32'h14,       1'b1,32'hE000_0010,32'h14};
    tv[10] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h18,       1'b1,32'hE000_0010,32'h14};
    tv[11] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h18,       1'b1,32'hE000_0010,32'h14};
    tv[12] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h18,       1'b1,32'hE000_0010,32'h14};
    tv[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h18,       1'b1,32'hE000_0014,32'h18};
    tv[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0018,1'b1,32'h18,       1'b1,32'hE000_0018,32'h1C};
    tv[15] = '{1'b0,1'b1,1'b1,32'h100,      1'b0,32'h0,        1'b1,32'h1C,       1'b0,32'hE000_0018,32'h1C};
    tv[16] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1C,       1'b0,32'hE000_0018,32'h1C};
    tv[17] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_001C,1'b1,32'h1C,       1'b0,32'hE000_0018,32'h1C};
    tv[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0100,1'b1,32'h100,      1'b1,32'hE000_0100,32'h104};
    tv[19] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hE000_0104,1'b1,32'h104,      1'b1,32'hE000_0100,32'h104};
    tv[20] = '{1'b0,1'b0,1'b1,32'h200,      1'b0,32'h0,        1'b0,32'h108,      1'b0,32'hE000_0100,32'h104};
    tv[21] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hE000_0200,1'b1,32'h200,      1'b1,32'hE000_0200,32'h204};
    tv[22] = '{1'b0,1'b1,1'b1,32'h300,      1'b0,32'h0,        1'b1,32'h204,      1'b0,32'hE000_0200,32'h204};
    tv[23] = '{1'b0,1'b1,1'b1,32'hFFFF_FFFC,1'b1,32'hDEAD_0204,1'b1,32'h204,      1'b0,32'hE000_0200,32'h204};
    tv[24] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h1234_5678,1'b1,32'hFFFF_FFFC,1'b1,32'h1234_5678,32'h0};
    tv[25] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hAAAA_0000,1'b1,32'h0,        1'b1,32'hAAAA_0000,32'h4};
    tv[26] = '{1'b0,1'b1,1'b1,32'h40,       1'b1,32'hDEAD_0004,1'b1,32'h4,        1'b0,32'hAAAA_0000,32'h4};
    tv[27] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hBBBB_0040,1'b1,32'h40,       1'b1,32'hBBBB_0040,32'h44};
    tv[28] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h44,       1'b1,32'hBBBB_0040,32'h44};
    reset_n = 1'b0; freeze = 1'b0; sram_ready = 1'b1; branch_taken = 1'b0;
    branch_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      freeze = tv[i].frz; sram_ready = tv[i].srdy; branch_taken = tv[i].bt;
      branch_addr = tv[i].baddr; imem_ack = tv[i].ack; imem_rdata = tv[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tv[i].req));
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d_instr", i), instruction, tv[i].ins);
      chk($sformatf("v%0d_pc_out", i), pc_out, tv[i].pco);
    end
    // async reset in the middle of a pending, stalled fetch
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    freeze = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    chk("post_idle_req", 32'(imem_req), 32'h1);
    chk("post_idle_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hC0DE_0000;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("post_rst_valid", 32'(inst_valid), 32'h1);
    chk("post_rst_instr", instruction, 32'hC0DE_0000);
    chk("post_rst_pc_out", pc_out, 32'h4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
